// File: rtl/bfly_out_serializer.sv
// bfly_out_serializer
// Re-serializes the butterfly output into one NUM-lane stream of 2*DEPTH beats.
// Sum beats (din1) are forwarded one cycle after acceptance; difference beats
// (din2) are stored and replayed back-to-back once the last sum beat is out.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   din1_re/din1_im     sum-path lanes, NUM x signed WIDTH
//   din2_re/din2_im     difference-path lanes, NUM x signed WIDTH
//   valid_in            din1/din2 beat valid
//   in_ready            beat can be accepted (low while draining)
//   dout_re/dout_im     registered serialized output lanes
//   valid_out           dout valid
//   dout_half           0 = sum beat, 1 = difference beat
//   dout_idx            beat index within the current half
//   ovf_err             sticky: a beat arrived while draining
//
// state | meaning
// IDLE  | waiting for first sum beat of a frame
// FILL  | forwarding sum beats, storing difference beats
// DRAIN | replaying stored difference beats, input stalled
module bfly_out_serializer #(
  parameter int WIDTH = 10,
  parameter int NUM   = 16,
  parameter int DEPTH = 16,
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] din1_re [NUM],
  input  logic signed [WIDTH-1:0] din1_im [NUM],
  input  logic signed [WIDTH-1:0] din2_re [NUM],
  input  logic signed [WIDTH-1:0] din2_im [NUM],
  input  logic                    valid_in,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] dout_re [NUM],
  output logic signed [WIDTH-1:0] dout_im [NUM],
  output logic                    valid_out,
  output logic                    dout_half,
  output logic [IW-1:0]           dout_idx,
  output logic                    ovf_err
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  state_t state, state_nxt;
  logic [IW-1:0] wr_ptr, rd_ptr;
  logic accept, draining;

  logic signed [WIDTH-1:0] mem_re [DEPTH][NUM];
  logic signed [WIDTH-1:0] mem_im [DEPTH][NUM];

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (valid_in) state_nxt = (DEPTH == 1) ? DRAIN : FILL;
      FILL:  if (valid_in && wr_ptr == LAST) state_nxt = DRAIN;
      DRAIN: if (rd_ptr == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // output / control decode
  always_comb begin
    in_ready = (state != DRAIN);
    accept   = valid_in && (state != DRAIN);
    draining = (state == DRAIN);
  end

  // wr_ptr is always 0 in IDLE, so IDLE and FILL share one write path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + IW'(1);
      if (draining) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + IW'(1);
    end
  end

  // difference buffer; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM; i++) begin
        mem_re[wr_ptr][i] <= din2_re[i];
        mem_im[wr_ptr][i] <= din2_im[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) begin
        dout_re[i] <= '0;
        dout_im[i] <= '0;
      end
      valid_out <= 1'b0;
      dout_half <= 1'b0;
      dout_idx  <= '0;
    end else if (draining) begin
      for (int i = 0; i < NUM; i++) begin
        dout_re[i] <= mem_re[rd_ptr][i];
        dout_im[i] <= mem_im[rd_ptr][i];
      end
      valid_out <= 1'b1;
      dout_half <= 1'b1;
      dout_idx  <= rd_ptr;
    end else if (accept) begin
      for (int i = 0; i < NUM; i++) begin
        dout_re[i] <= din1_re[i];
        dout_im[i] <= din1_im[i];
      end
      valid_out <= 1'b1;
      dout_half <= 1'b0;
      dout_idx  <= wr_ptr;
    end else begin
      valid_out <= 1'b0;
    end
  end

  // a beat offered during DRAIN is dropped; remember that it happened
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        ovf_err <= 1'b0;
    else if (valid_in && draining)  ovf_err <= 1'b1;
  end

endmodule

// File: tb/tb_bfly_out_serializer.sv
module tb_bfly_out_serializer;
  localparam int W = 10;
  localparam int N = 16;
  localparam int D = 16;
  localparam int PW = N * W;

  typedef struct packed {
    logic [PW-1:0] re;
    logic [PW-1:0] im;
    logic          half;
    logic [3:0]    idx;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic signed [W-1:0] d1re [N], d1im [N], d2re [N], d2im [N];
  logic signed [W-1:0] ore [N], oim [N];
  logic valid_in, in_ready, valid_out, dout_half, ovf_err;
  logic [3:0] dout_idx;

  bfly_out_serializer #(.WIDTH(W), .NUM(N), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .din1_re(d1re), .din1_im(d1im), .din2_re(d2re), .din2_im(d2im),
    .valid_in(valid_in), .in_ready(in_ready),
    .dout_re(ore), .dout_im(oim), .valid_out(valid_out),
    .dout_half(dout_half), .dout_idx(dout_idx), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  beat_t exp_q[$];
  int passed = 0, total = 0;
  int cyc = 0, irlow, vcount, first, last, dcount, dfirst, dlast;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic logic [PW-1:0] pk(input logic signed [W-1:0] a [N]);
    logic [PW-1:0] v;
    for (int l = 0; l < N; l++) v[l*W +: W] = a[l];
    return v;
  endfunction

  // kind: 0=sum re, 1=sum im, 2=diff re, 3=diff im
  function automatic logic [W-1:0] lane_val(input int seed, input int k, input int l,
                                            input int kind, input bit ext);
    if (ext) return ((k + kind) % 2 == 0) ? 10'h200 : 10'h1FF;
    case (kind)
      0: return (l == 0) ? W'(k) : W'(seed + k * 16 + l);
      1: return W'(seed * 3 - k * 5 + l * 7);
      2: return (l == 0) ? W'(-k - 1) : W'(seed - k * 16 - l);
      default: return W'(seed ^ (k << 4) ^ l);
    endcase
  endfunction

  task automatic clr_mon();
    irlow = 0; vcount = 0; first = -1; last = -1;
    dcount = 0; dfirst = -1; dlast = -1;
  endtask

  task automatic mon();
    beat_t e;
    cyc++;
    if (!in_ready) irlow++;
    if (valid_out) begin
      chk("sb_nonempty", 512'(exp_q.size() != 0), 512'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dout_re", pk(ore), e.re);
        chk("dout_im", pk(oim), e.im);
        chk("dout_half", dout_half, e.half);
        chk("dout_idx", dout_idx, e.idx);
      end
      vcount++;
      if (first < 0) first = cyc;
      last = cyc;
      if (dout_half) begin
        dcount++;
        if (dfirst < 0) dfirst = cyc;
        dlast = cyc;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      mon();
    end
  endtask

  task automatic run_frame(input int seed, input int gap_a, input int gap_b, input bit ext);
    beat_t dq [D];
    beat_t s;
    for (int k = 0; k < D; k++) begin
      for (int l = 0; l < N; l++) begin
        d1re[l] = lane_val(seed, k, l, 0, ext);
        d1im[l] = lane_val(seed, k, l, 1, ext);
        d2re[l] = lane_val(seed, k, l, 2, ext);
        d2im[l] = lane_val(seed, k, l, 3, ext);
      end
      s.re = pk(d1re); s.im = pk(d1im); s.half = 1'b0; s.idx = 4'(k);
      exp_q.push_back(s);
      dq[k].re = pk(d2re); dq[k].im = pk(d2im); dq[k].half = 1'b1; dq[k].idx = 4'(k);
      if (k == D - 1) for (int j = 0; j < D; j++) exp_q.push_back(dq[j]);
      valid_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mon();
      valid_in = 1'b0;
      if (k == gap_a || k == gap_b) idle(1);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    valid_in = 1'b0;
    for (int l = 0; l < N; l++) begin
      d1re[l] = '0; d1im[l] = '0; d2re[l] = '0; d2im[l] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_dout_re", pk(ore), '0);
    chk("rst_dout_im", pk(oim), '0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_half", dout_half, 0);
    chk("rst_idx", dout_idx, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_in_ready", in_ready, 1);

    // full contiguous frame
    clr_mon();
    run_frame(0, -1, -1, 0);
    idle(20);
    chk("full_vcount", vcount, 32);
    chk("full_contig", last - first + 1, 32);
    chk("full_ready_low", irlow, 16);
    chk("full_q_empty", exp_q.size(), 0);
    chk("full_ovf", ovf_err, 0);

    // gaps after beats 3 and 9
    clr_mon();
    run_frame(100, 3, 9, 0);
    idle(20);
    chk("gap_vcount", vcount, 32);
    chk("gap_span", last - first + 1, 34);
    chk("gap_drain_cnt", dcount, 16);
    chk("gap_drain_contig", dlast - dfirst + 1, 16);
    chk("gap_q_empty", exp_q.size(), 0);
    chk("gap_ovf", ovf_err, 0);

    // back-to-back frames
    clr_mon();
    run_frame(200, -1, -1, 0);
    n = 0;
    while (!in_ready && n < 40) begin
      idle(1);
      n++;
    end
    chk("b2b_ready_wait", in_ready, 1);
    run_frame(300, -1, -1, 0);
    idle(20);
    chk("b2b_vcount", vcount, 64);
    chk("b2b_contig", last - first + 1, 64);
    chk("b2b_q_empty", exp_q.size(), 0);

    // overflow pulse in the 5th drain cycle
    clr_mon();
    run_frame(400, -1, -1, 0);
    idle(4);
    chk("ovf_before", ovf_err, 0);
    chk("ovf_ready_low", in_ready, 0);
    for (int l = 0; l < N; l++) begin
      d1re[l] = 10'h155; d1im[l] = 10'h0AA; d2re[l] = 10'h1FF; d2im[l] = 10'h1FF;
    end
    valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mon();
    valid_in = 1'b0;
    chk("ovf_set", ovf_err, 1);
    idle(20);
    chk("ovf_sticky", ovf_err, 1);
    chk("ovf_vcount", vcount, 32);
    chk("ovf_q_empty", exp_q.size(), 0);

    // reset during drain beat 7
    clr_mon();
    run_frame(500, -1, -1, 0);
    idle(8);
    chk("mid_idx_pre", dout_idx, 7);
    #2 rst = 1'b1;
    #1;
    chk("mid_dout_re", pk(ore), '0);
    chk("mid_dout_im", pk(oim), '0);
    chk("mid_valid", valid_out, 0);
    chk("mid_half", dout_half, 0);
    chk("mid_idx", dout_idx, 0);
    chk("mid_ovf", ovf_err, 0);
    chk("mid_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    clr_mon();
    run_frame(600, -1, -1, 0);
    idle(20);
    chk("mid_new_vcount", vcount, 32);
    chk("mid_new_q_empty", exp_q.size(), 0);

    // extremes: -512 / +511 on every lane
    clr_mon();
    run_frame(0, -1, -1, 1);
    idle(20);
    chk("ext_vcount", vcount, 32);
    chk("ext_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bfly_out_serializer.md
Name: bfly_out_serializer

Overview:
- Downstream partner of the butterfly stage. The butterfly takes a 2×DEPTH-beat stream and emits DEPTH beats, each carrying a sum block (din1) and a difference block (din2) at the same time.
- This block turns those beats back into one NUM-lane stream of 2×DEPTH beats for the next FFT stage.
- Each sum beat is forwarded straight away. Each difference beat is stored, and the stored beats are replayed back-to-back once all sum beats have gone out.

Parameters:
- WIDTH, 10, bit width of each real/imaginary sample (matches the butterfly output width).
- NUM, 16, number of parallel lanes per beat.
- DEPTH, 16, number of beats per half-frame (sum half = diff half = DEPTH beats).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- din1_re  in  signed [WIDTH-1:0] x NUM  sum-path real.
- din1_im  in  signed [WIDTH-1:0] x NUM  sum-path imaginary.
- din2_re  in  signed [WIDTH-1:0] x NUM  difference-path real.
- din2_im  in  signed [WIDTH-1:0] x NUM  difference-path imaginary.
- valid_in  in  1  the din1/din2 beat is valid.
- in_ready  out  1  block can accept a beat; combinational, equals (state != DRAIN).
- dout_re  out  signed [WIDTH-1:0] x NUM  serialized real output, registered.
- dout_im  out  signed [WIDTH-1:0] x NUM  serialized imaginary output, registered.
- valid_out  out  1  dout is valid.
- dout_half  out  1  0 = beat comes from din1 (sum), 1 = beat comes from din2 (difference).
- dout_idx  out  $clog2(DEPTH)  beat index within the current half.
- ovf_err  out  1  sticky flag: a beat arrived while the block was not ready.

Behaviour:
- Reset (async, rst=1): state=IDLE, wr_ptr=0, rd_ptr=0, all dout lanes=0, valid_out=0, dout_half=0, dout_idx=0, ovf_err=0. Buffer contents are don't-care.
- Buffer: DEPTH entries, each holding NUM×2×WIDTH bits. Written at wr_ptr, read at rd_ptr.
- Only rst clears ovf_err.
- States are IDLE, FILL and DRAIN.
- IDLE, valid_in=1:
  - Register din1 into dout; valid_out=1, dout_half=0, dout_idx=0.
  - Write din2 into buf[0]; wr_ptr=1; go to FILL.
  - If DEPTH==1, go directly to DRAIN.
- FILL, valid_in=1:
  - Forward din1 as above with dout_idx=wr_ptr, and write buf[wr_ptr].
  - If wr_ptr==DEPTH-1: wr_ptr wraps to 0 and state goes to DRAIN. Otherwise wr_ptr increments.
- FILL, valid_in=0: gaps are allowed. State and pointers hold and valid_out=0 for that cycle.
- DRAIN, every cycle (ignores valid_in):
  - dout<=buf[rd_ptr]; valid_out=1, dout_half=1, dout_idx=rd_ptr.
  - If rd_ptr==DEPTH-1: rd_ptr wraps to 0 and state goes to IDLE. Otherwise rd_ptr increments.
- Latency:
  - Sum beat k appears 1 cycle after it is accepted.
  - If the last sum beat is accepted in cycle t: buf[0] appears at t+2, and buf[DEPTH-1] appears at t+DEPTH+1.
  - With gap-free input, output is 2×DEPTH contiguous valid beats.
- Back-to-back frames:
  - in_ready=0 for the DEPTH DRAIN cycles.
  - A new frame may be accepted in the cycle after the last DRAIN cycle. Its first sum beat appears directly after the last diff beat, with no output bubble.
- valid_in=1 while in DRAIN: the beat is dropped, ovf_err is set to 1, and the drain sequence is unaffected.
- No arithmetic: samples pass through bit-exact at WIDTH bits, sign preserved, no rounding or saturation.
- Reset mid-frame (FILL or DRAIN): the frame is aborted immediately and the block returns to the reset values. The next valid_in starts a fresh frame at index 0.
- valid_out=0 in all cycles not listed above; dout then holds its last value.

Test Plan:
- Reset check: assert rst for 3 cycles, then deassert -> every output reads 0 and in_ready=1.
- Full contiguous frame with DEPTH=16: din1_re lane0=k and din2_re lane0=-k-1 for beats k=0..15, valid for 16 cycles.
  - Expect 32 contiguous valid_out beats.
  - Beats 0..15: dout_re lane0=0..15, dout_half=0.
  - Beats 16..31: dout_re lane0=-1..-16, dout_half=1, dout_idx=0..15.
  - in_ready low for exactly 16 cycles.
- Gappy fill: insert valid_in=0 bubbles after beats 3 and 9 -> sum outputs show the same bubbles, diff drain stays contiguous 16 beats, data order unchanged, ovf_err=0.
- Back-to-back frames: drive frame B the cycle in_ready returns high -> 64 contiguous valid beats; frame B sum beat 0 directly follows frame A diff beat 15.
- Overflow: pulse valid_in in the 5th DRAIN cycle with din2=0x1FF -> ovf_err=1 from the next cycle and stays 1, drain data unchanged, beat dropped.
- Reset mid-DRAIN: assert rst during drain beat 7 -> outputs go to 0 asynchronously; a new frame then outputs from dout_idx=0 with correct data.
- Extremes: lane values 0x200 (-512) and 0x1FF (+511) on all 16 lanes -> output is bit-exact, sign preserved.
